// File: rtl/risc_pkg.sv
// Shared types and constants for the ID/EX operand stage: widths, ALU opcodes,
// control bundle and the full ID/EX register image.
package risc_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned REGW = 5;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLL = 3'b100,
        ALU_SRL = 3'b101
    } alu_op_e;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
    } idex_ctrl_t;

    localparam idex_ctrl_t IDEX_BUBBLE = '0;

    typedef struct packed {
        logic            valid;
        logic [REGW-1:0] rs1;
        logic [REGW-1:0] rs2;
        logic [REGW-1:0] rd;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic            use_imm;
        alu_op_e         alu_op;
        idex_ctrl_t      ctrl;
    } idex_reg_t;

    // A write to x0 is never a real producer.
    function automatic logic rd_match(input logic [REGW-1:0] rd, input logic we,
                                      input logic [REGW-1:0] rs);
        return we && (rd != '0) && (rd == rs);
    endfunction

endpackage

// File: rtl/risc_ex_operand_stage_if.sv
// Bundle of ID-side, bypass-source and EX-side signals around the ID/EX stage.
interface risc_ex_operand_stage_if;
    import risc_pkg::*;

    logic            stall;
    logic            flush;
    logic            id_valid;
    logic [REGW-1:0] id_rs1;
    logic [REGW-1:0] id_rs2;
    logic [REGW-1:0] id_rd;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic [XLEN-1:0] id_imm;
    logic            id_use_imm;
    logic [2:0]      id_alu_op;
    logic            id_reg_write;
    logic            id_mem_read;
    logic            id_mem_write;
    logic            id_branch;
    logic [REGW-1:0] exmem_rd;
    logic            exmem_reg_write;
    logic [XLEN-1:0] exmem_alu_out;
    logic [REGW-1:0] memwb_rd;
    logic            memwb_reg_write;
    logic [XLEN-1:0] memwb_wdata;

    logic            hazard_stall;
    logic            ex_valid;
    logic [XLEN-1:0] ex_operand_a;
    logic [XLEN-1:0] ex_operand_b;
    logic [XLEN-1:0] ex_store_data;
    logic [2:0]      ex_alu_op;
    logic [REGW-1:0] ex_rd;
    logic            ex_reg_write;
    logic            ex_mem_read;
    logic            ex_mem_write;
    logic            ex_branch;

    modport master (
        output stall, flush, id_valid, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data,
               id_imm, id_use_imm, id_alu_op, id_reg_write, id_mem_read, id_mem_write,
               id_branch, exmem_rd, exmem_reg_write, exmem_alu_out, memwb_rd,
               memwb_reg_write, memwb_wdata,
        input  hazard_stall, ex_valid, ex_operand_a, ex_operand_b, ex_store_data, ex_alu_op,
               ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch
    );

    modport slave (
        input  stall, flush, id_valid, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data,
               id_imm, id_use_imm, id_alu_op, id_reg_write, id_mem_read, id_mem_write,
               id_branch, exmem_rd, exmem_reg_write, exmem_alu_out, memwb_rd,
               memwb_reg_write, memwb_wdata,
        output hazard_stall, ex_valid, ex_operand_a, ex_operand_b, ex_store_data, ex_alu_op,
               ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch
    );

endinterface

// File: rtl/risc_fwd_mux.sv
// Three-way bypass select for one source operand; EX/MEM beats MEM/WB, x0 never bypassed.
module risc_fwd_mux
    import risc_pkg::*;
(
    input  logic            fwd_en,
    input  logic [REGW-1:0] rs,
    input  logic [XLEN-1:0] rs_data,
    input  logic [REGW-1:0] exmem_rd,
    input  logic            exmem_reg_write,
    input  logic [XLEN-1:0] exmem_data,
    input  logic [REGW-1:0] memwb_rd,
    input  logic            memwb_reg_write,
    input  logic [XLEN-1:0] memwb_data,
    output logic [XLEN-1:0] fwd_data
);

    always_comb begin
        fwd_data = rs_data;
        if (fwd_en && rd_match(exmem_rd, exmem_reg_write, rs)) begin
            fwd_data = exmem_data;
        end else if (fwd_en && rd_match(memwb_rd, memwb_reg_write, rs)) begin
            fwd_data = memwb_data;
        end
    end

endmodule

// File: rtl/risc_ex_operand_stage.sv
// ID/EX pipeline register with hazard detection and operand bypass.
// RISC_EX_FORWARD_EN enables bypassing; otherwise every producer RAW stalls.
module risc_ex_operand_stage
    import risc_pkg::*;
(
    input logic                   clk,
    input logic                   rst_n,
    risc_ex_operand_stage_if.slave bus
);

    idex_reg_t       idex_q, idex_d, id_word;
    logic            raw_hazard;
    logic            fwd_en;
    logic [XLEN-1:0] fwd_rs1, fwd_rs2;

`ifdef RISC_EX_FORWARD_EN
    assign fwd_en     = 1'b1;
    // Only a load in EX cannot be bypassed in time.
    assign raw_hazard = idex_q.valid && idex_q.ctrl.mem_read && bus.id_valid &&
                        (rd_match(idex_q.rd, 1'b1, bus.id_rs1) ||
                         rd_match(idex_q.rd, 1'b1, bus.id_rs2));
`else
    assign fwd_en     = 1'b0;
    // Register file is write-before-read, so MEM/WB producers need no stall.
    assign raw_hazard = bus.id_valid &&
                        (rd_match(idex_q.rd, idex_q.valid && idex_q.ctrl.reg_write, bus.id_rs1) ||
                         rd_match(idex_q.rd, idex_q.valid && idex_q.ctrl.reg_write, bus.id_rs2) ||
                         rd_match(bus.exmem_rd, bus.exmem_reg_write, bus.id_rs1) ||
                         rd_match(bus.exmem_rd, bus.exmem_reg_write, bus.id_rs2));
`endif

    assign bus.hazard_stall = rst_n && !bus.flush && raw_hazard;

    always_comb begin
        id_word                = '0;
        id_word.valid          = bus.id_valid;
        id_word.rs1            = bus.id_rs1;
        id_word.rs2            = bus.id_rs2;
        id_word.rd             = bus.id_rd;
        id_word.rs1_data       = bus.id_rs1_data;
        id_word.rs2_data       = bus.id_rs2_data;
        id_word.imm            = bus.id_imm;
        id_word.use_imm        = bus.id_use_imm;
        id_word.alu_op         = alu_op_e'(bus.id_alu_op);
        id_word.ctrl.reg_write = bus.id_reg_write;
        id_word.ctrl.mem_read  = bus.id_mem_read;
        id_word.ctrl.mem_write = bus.id_mem_write;
        id_word.ctrl.branch    = bus.id_branch;
    end

    // Priority: flush, then stall (hold), then load-use bubble, then capture.
    always_comb begin
        idex_d = idex_q;
        if (bus.flush || (!bus.stall && bus.hazard_stall)) begin
            idex_d        = '0;
            idex_d.alu_op = ALU_ADD;
            idex_d.ctrl   = IDEX_BUBBLE;
        end else if (!bus.stall) begin
            idex_d = id_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    risc_fwd_mux u_fwd_rs1 (
        .fwd_en          (fwd_en),
        .rs              (idex_q.rs1),
        .rs_data         (idex_q.rs1_data),
        .exmem_rd        (bus.exmem_rd),
        .exmem_reg_write (bus.exmem_reg_write),
        .exmem_data      (bus.exmem_alu_out),
        .memwb_rd        (bus.memwb_rd),
        .memwb_reg_write (bus.memwb_reg_write),
        .memwb_data      (bus.memwb_wdata),
        .fwd_data        (fwd_rs1)
    );

    risc_fwd_mux u_fwd_rs2 (
        .fwd_en          (fwd_en),
        .rs              (idex_q.rs2),
        .rs_data         (idex_q.rs2_data),
        .exmem_rd        (bus.exmem_rd),
        .exmem_reg_write (bus.exmem_reg_write),
        .exmem_data      (bus.exmem_alu_out),
        .memwb_rd        (bus.memwb_rd),
        .memwb_reg_write (bus.memwb_reg_write),
        .memwb_data      (bus.memwb_wdata),
        .fwd_data        (fwd_rs2)
    );

    assign bus.ex_valid      = idex_q.valid;
    assign bus.ex_operand_a  = fwd_rs1;
    assign bus.ex_operand_b  = idex_q.use_imm ? idex_q.imm : fwd_rs2;
    assign bus.ex_store_data = fwd_rs2;
    assign bus.ex_alu_op     = idex_q.alu_op;
    assign bus.ex_rd         = idex_q.rd;
    assign bus.ex_reg_write  = idex_q.ctrl.reg_write;
    assign bus.ex_mem_read   = idex_q.ctrl.mem_read;
    assign bus.ex_mem_write  = idex_q.ctrl.mem_write;
    assign bus.ex_branch     = idex_q.ctrl.branch;

endmodule

// File: tb/tb_risc_ex_operand_stage.sv
// Directed bench for risc_ex_operand_stage; expectations follow RISC_EX_FORWARD_EN.
module tb_risc_ex_operand_stage;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    risc_ex_operand_stage_if bus ();

    risc_ex_operand_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

`ifdef RISC_EX_FORWARD_EN
    localparam bit Fwd = 1'b1;
`else
    localparam bit Fwd = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                            input logic [31:0] imm, input logic use_imm, input logic [2:0] op,
                            input logic rw, input logic mr, input logic mw, input logic br);
        bus.id_valid     = v;
        bus.id_rs1       = rs1;
        bus.id_rs2       = rs2;
        bus.id_rd        = rd;
        bus.id_rs1_data  = d1;
        bus.id_rs2_data  = d2;
        bus.id_imm       = imm;
        bus.id_use_imm   = use_imm;
        bus.id_alu_op    = op;
        bus.id_reg_write = rw;
        bus.id_mem_read  = mr;
        bus.id_mem_write = mw;
        bus.id_branch    = br;
    endtask

    task automatic drive_byp(input logic [4:0] erd, input logic ew, input logic [31:0] eout,
                             input logic [4:0] wrd, input logic ww, input logic [31:0] wdat);
        bus.exmem_rd        = erd;
        bus.exmem_reg_write = ew;
        bus.exmem_alu_out   = eout;
        bus.memwb_rd        = wrd;
        bus.memwb_reg_write = ww;
        bus.memwb_wdata     = wdat;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        // Inputs that would raise a hazard outside reset.
        drive_id(1, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive_byp(3, 1, 32'h77, 0, 0, 0);
        #2;
        check("reset_valid", bus.ex_valid, 0);
        check("reset_alu_op", bus.ex_alu_op, 0);
        check("reset_rd", bus.ex_rd, 0);
        check("reset_op_a", bus.ex_operand_a, 0);
        check("reset_hazard", bus.hazard_stall, 0);
        drive_byp(0, 0, 0, 0, 0, 0);
        #6;
        rst_n = 1'b1;

        // Independent add x5 = x1 + x2.
        drive_id(1, 1, 2, 5, 5, 7, 0, 0, 3'b000, 1, 0, 0, 0);
        #1;
        check("add_hazard", bus.hazard_stall, 0);
        tick();
        check("add_valid", bus.ex_valid, 1);
        check("add_op_a", bus.ex_operand_a, 5);
        check("add_op_b", bus.ex_operand_b, 7);
        check("add_rd", bus.ex_rd, 5);
        check("add_reg_write", bus.ex_reg_write, 1);

        // Back-to-back sub with stale rs1 data and immediate operand B.
        drive_id(1, 3, 4, 6, 0, 9, 32'h100, 1, 3'b001, 1, 0, 0, 0);
        #1;
        check("sub_hazard", bus.hazard_stall, 0);
        tick();
        bus.stall = 1'b1;
        drive_id(1, 7, 8, 13, 32'hDEAD, 32'hBEEF, 0, 0, 3'b011, 1, 0, 0, 1);
        drive_byp(3, 1, 32'h10, 0, 0, 0);
        #1;
        check("exmem_op_a", bus.ex_operand_a, Fwd ? 32'h10 : 32'h0);
        check("sub_op_b_imm", bus.ex_operand_b, 32'h100);
        check("sub_alu_op", bus.ex_alu_op, 3'b001);
        drive_byp(3, 1, 32'h10, 3, 1, 32'h20);
        #1;
        check("exmem_wins", bus.ex_operand_a, Fwd ? 32'h10 : 32'h0);
        tick();
        check("stall_hold_rd", bus.ex_rd, 6);
        check("stall_hold_branch", bus.ex_branch, 0);
        drive_byp(3, 0, 32'h10, 3, 1, 32'h20);
        #1;
        check("memwb_op_a", bus.ex_operand_a, Fwd ? 32'h20 : 32'h0);
        drive_byp(3, 0, 32'h10, 4, 1, 32'h44);
        #1;
        check("memwb_store", bus.ex_store_data, Fwd ? 32'h44 : 32'h9);
        check("imm_over_fwd", bus.ex_operand_b, 32'h100);

        // x0 never bypassed.
        bus.stall = 1'b0;
        drive_id(1, 0, 0, 7, 0, 0, 0, 0, 3'b010, 1, 0, 0, 0);
        drive_byp(0, 1, 32'hFF, 0, 1, 32'hEE);
        tick();
        check("x0_op_a", bus.ex_operand_a, 0);
        check("x0_op_b", bus.ex_operand_b, 0);
        check("x0_alu_op", bus.ex_alu_op, 3'b010);

        // lw x4, 8(x0) followed by add x9 = x1 + x4.
        drive_byp(0, 0, 0, 0, 0, 0);
        drive_id(1, 0, 0, 4, 32'h1000, 0, 8, 1, 3'b000, 1, 1, 0, 0);
        tick();
        check("lw_mem_read", bus.ex_mem_read, 1);
        check("lw_op_b", bus.ex_operand_b, 8);
        drive_id(1, 1, 4, 9, 5, 0, 0, 0, 3'b000, 1, 0, 0, 0);
        #1;
        check("loaduse_hazard", bus.hazard_stall, 1);
        tick();
        check("bubble_valid", bus.ex_valid, 0);
        check("bubble_reg_write", bus.ex_reg_write, 0);
        check("bubble_mem_read", bus.ex_mem_read, 0);
        drive_byp(4, 1, 32'h1008, 0, 0, 0);
        #1;
        check("lw_in_mem_hazard", bus.hazard_stall, Fwd ? 1'b0 : 1'b1);
        tick();
        if (Fwd) begin
            drive_byp(0, 0, 0, 4, 1, 32'hABCD);
            #1;
        end else begin
            check("second_bubble", bus.ex_valid, 0);
            drive_byp(0, 0, 0, 4, 1, 32'hABCD);
            bus.id_rs2_data = 32'hABCD;
            #1;
            check("wb_no_hazard", bus.hazard_stall, 0);
            tick();
        end
        check("add_after_lw_valid", bus.ex_valid, 1);
        check("add_after_lw_op_a", bus.ex_operand_a, 5);
        check("add_after_lw_op_b", bus.ex_operand_b, 32'hABCD);
        check("add_after_lw_rd", bus.ex_rd, 9);

        // Flush beats stall and a pending load-use hazard.
        drive_byp(0, 0, 0, 0, 0, 0);
        drive_id(1, 0, 0, 10, 32'h2000, 0, 4, 1, 3'b000, 1, 1, 0, 0);
        tick();
        drive_id(1, 10, 0, 11, 3, 0, 0, 0, 3'b011, 1, 0, 0, 0);
        #1;
        check("pre_flush_hazard", bus.hazard_stall, 1);
        bus.flush = 1'b1;
        bus.stall = 1'b1;
        #1;
        check("flush_hazard", bus.hazard_stall, 0);
        tick();
        check("flush_valid", bus.ex_valid, 0);
        check("flush_reg_write", bus.ex_reg_write, 0);
        check("flush_mem_read", bus.ex_mem_read, 0);
        check("flush_rd", bus.ex_rd, 0);
        check("flush_op_a", bus.ex_operand_a, 0);
        bus.flush = 1'b0;
        bus.stall = 1'b0;

        // Asynchronous reset while a valid instruction sits in EX.
        drive_id(1, 1, 2, 12, 32'h33, 32'h44, 0, 0, 3'b011, 1, 0, 0, 0);
        tick();
        check("pre_reset_valid", bus.ex_valid, 1);
        check("pre_reset_op_a", bus.ex_operand_a, 32'h33);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_valid", bus.ex_valid, 0);
        check("async_rd", bus.ex_rd, 0);
        check("async_op_a", bus.ex_operand_a, 0);
        check("async_alu_op", bus.ex_alu_op, 0);
        check("async_reg_write", bus.ex_reg_write, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/risc_ex_operand_stage.md
# risc_ex_operand_stage

ID/EX pipeline register with load-use hazard detection and operand forwarding, sitting directly upstream of the execute-stage ALU. It captures decoded instruction fields at each clock edge. It resolves RAW hazards by bypassing from EX/MEM and MEM/WB, or by inserting a one-cycle bubble on load-use. It drives the ALU's `operandA`, `operandB` and `alu_op` inputs.

## Interface
- `XLEN`, 32, datapath width
- `REGW`, 5, register index width
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `stall`  in  1  downstream hold; register keeps its contents
- `flush`  in  1  branch/jump flush; register loads a bubble
- `id_valid`  in  1  decoded instruction present
- `id_rs1`, `id_rs2`, `id_rd`  in  REGW  source and destination indices
- `id_rs1_data`, `id_rs2_data`  in  XLEN  register file read data
- `id_imm`  in  XLEN  sign-extended immediate
- `id_use_imm`  in  1  operand B is the immediate
- `id_alu_op`  in  3  ALU opcode (000 add, 001 sub, 010 and, 011 or, 100 sll, 101 srl)
- `id_reg_write`, `id_mem_read`, `id_mem_write`, `id_branch`  in  1  control bits
- `exmem_rd`  in  REGW, `exmem_reg_write`  in  1, `exmem_alu_out`  in  XLEN  EX/MEM bypass source
- `memwb_rd`  in  REGW, `memwb_reg_write`  in  1, `memwb_wdata`  in  XLEN  MEM/WB bypass source
- `hazard_stall`  out  1  load-use detected; PC and IF/ID must hold
- `ex_valid`  out  1  EX slot holds a real instruction
- `ex_operand_a`, `ex_operand_b`  out  XLEN  ALU operands
- `ex_store_data`  out  XLEN  forwarded rs2 value for stores
- `ex_alu_op`  out  3; `ex_rd`  out  REGW
- `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_branch`  out  1

## Operation
- **Registered fields:** valid, rs1, rs2, rd, rs1_data, rs2_data, imm, use_imm, alu_op, and the four control bits.
- **Update priority at each rising edge:**
  - flush: load a bubble (valid and all control bits 0, alu_op 000; data fields don't-care, cleared to 0).
  - else stall: hold.
  - else hazard_stall: load a bubble.
  - else: load the `id_*` inputs.
- **hazard_stall** is combinational: `ex_valid & ex_mem_read & ex_rd!=0 & id_valid & (id_rs1==ex_rd | (id_rs2==ex_rd & !id_use_imm & !id_mem_write ? …))`.
  - Simplified rule: the hazard is flagged when `id_rs1==ex_rd` or `id_rs2==ex_rd`. The rs2 comparison always applies, because stores need rs2.
  - hazard_stall is forced to 0 while `flush` is high.
- **Forwarding for operand A** (combinational from registered rs1):
  - EX/MEM if `exmem_reg_write & exmem_rd!=0 & exmem_rd==rs1`;
  - else MEM/WB if `memwb_reg_write & memwb_rd!=0 & memwb_rd==rs1`;
  - else registered rs1_data.
- **Forwarding for rs2:** same rule produces the forwarded rs2 value, which drives `ex_store_data`.
- **Operand B:** `ex_operand_b = use_imm ? imm : forwarded rs2`.
- **Register x0** is never forwarded. Both bypass sources matching the same register: EX/MEM wins.
- Outputs reflect the bubble's zero control bits when `ex_valid=0`. Operands remain computed but are harmless.

## Timing
- Capture latency: 1 cycle, ID inputs at edge N appear on `ex_*` after edge N.
- Forwarding and hazard paths are purely combinational; zero added latency.
- Reset (async, `rst_n` low): every registered field is 0.
  - Therefore `ex_valid`=0, all control outputs 0, `ex_alu_op`=000, `ex_rd`=0, operands 0 unless a bypass source matches (rd=0 never matches).
  - `hazard_stall`=0 during reset.
- A reset asserted mid-stall discards the held instruction. Flush and stall in the same cycle: flush wins.
- Load-use costs exactly one bubble. On the next cycle the load sits in MEM and is bypassed from MEM/WB one cycle later via normal forwarding.

## Configuration
- `RISC_EX_FORWARD_EN` defined: forwarding as above. Only load-use raises hazard_stall.
- Not defined:
  - No bypass muxes; operands come from the registered register-file data only.
  - hazard_stall is raised for any RAW between an ID source and a valid `ex_rd` with `ex_reg_write`, or `exmem_rd` with `exmem_reg_write`, where rd is non-zero.
  - The register file is write-before-read, so MEM/WB needs no stall.

## Structure
- Shared package `risc_pkg`: `XLEN`, `REGW`, ALU opcode enum (`ALU_ADD`..`ALU_SRL`), packed struct `idex_ctrl_t` {reg_write, mem_read, mem_write, branch}, bubble constant `IDEX_BUBBLE`.
- One sub-module: `risc_fwd_mux`, a 3-way bypass select for one operand, instantiated twice (rs1, rs2).

## Test plan
- Back-to-back independent adds: x1=5, x2=7, op 000 → next cycle `ex_operand_a`=5, `ex_operand_b`=7, `ex_valid`=1.
- EX/MEM bypass: exmem_rd=3, reg_write=1, alu_out=0x10; EX instruction rs1=3 with stale data 0 → `ex_operand_a`=0x10. Same case with memwb_rd=3 also writing 0x20 → still 0x10.
- x0 bypass: exmem_rd=0, alu_out=0xFF, rs1=0 → operand A = registered data 0.
- Load-use: EX holds lw x4 (mem_read=1, rd=4); ID holds add rs2=4 → `hazard_stall`=1 that cycle, next cycle `ex_valid`=0, and the add enters the cycle after with operand B bypassed from MEM/WB.
- Flush with stall and hazard all high → next cycle `ex_valid`=0, control 0, `hazard_stall`=0 during flush.
- Async reset asserted mid-cycle while valid=1 → outputs zero immediately, before the next edge.
